// File: rtl/cipher_uart_tx_if.sv
// pb1 I/O port bundle shared by the cipher PicoBlaze and its UART output stage.
interface cipher_uart_tx_if;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] status;

    modport master (output port_id, out_port, write_strobe, read_strobe, input status);
    modport slave  (input port_id, out_port, write_strobe, read_strobe, output status);
endinterface

// File: rtl/cipher_uart_tx.sv
// Ciphertext output stage: pb1 port writes -> byte FIFO -> 8N1 UART, plus a polled status byte.
// Define CIPHER_TX_PARITY_EN to add an even-parity bit (8E1) and advertise it in status bit4.
module cipher_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [7:0]  DATA_PORT    = 8'h20,
    parameter logic [7:0]  STATUS_PORT  = 8'h21
) (
    input  logic             clk,
    input  logic             reset,
    cipher_uart_tx_if.slave  pb,
    output logic             tx,
    output logic             busy
);
    localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
    localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
    localparam int unsigned PtrW  = AddrW + 1;
    localparam logic [CntW-1:0] Reload = CntW'(CLKS_PER_BIT - 1);
`ifdef CIPHER_TX_PARITY_EN
    localparam logic ParityEn = 1'b1;
`else
    localparam logic ParityEn = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop
`ifdef CIPHER_TX_PARITY_EN
        , StParity
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [7:0]        mem [FIFO_DEPTH];
    logic              overflow_q, overflow_d;
    logic [7:0]        status_q, status_d;
    logic [7:0]        head;
    logic              fifo_empty, fifo_full;
    logic              push_req, push_ok, pop, stat_rd;

    assign head       = mem[rd_ptr_q[AddrW-1:0]];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                        (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign push_req   = pb.write_strobe && (pb.port_id == DATA_PORT);
    assign stat_rd    = pb.read_strobe && (pb.port_id == STATUS_PORT);
    // A pop on the same edge frees the slot the push would otherwise be refused for.
    assign push_ok    = push_req && (!fifo_full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    cnt_d   = Reload;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == '0) begin
                    cnt_d   = Reload;
                    bit_d   = 3'd0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == '0) begin
                    cnt_d   = Reload;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef CIPHER_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
`ifdef CIPHER_TX_PARITY_EN
            StParity: begin
                if (cnt_q == '0) begin
                    cnt_d   = Reload;
                    state_d = StStop;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
`endif
            StStop: begin
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef CIPHER_TX_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)    parity_q <= 1'b0;
        else if (pop) parity_q <= ^head;
    end
`endif

    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_q[0];
`ifdef CIPHER_TX_PARITY_EN
            StParity: tx_d = parity_q;
`endif
            default:  tx_d = 1'b1;
        endcase
        busy = (state_q != StIdle) || !fifo_empty;
    end

    // Set beats clear when an overflowing push meets a status read.
    assign overflow_d = (push_req && fifo_full && !pop) ? 1'b1 :
                        stat_rd                         ? 1'b0 : overflow_q;
    assign status_d   = {3'b000, ParityEn, overflow_q, (state_q != StIdle), fifo_full, fifo_empty};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            status_q   <= 8'h01;
        end else begin
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            wr_ptr_q   <= wr_ptr_q + PtrW'(push_ok);
            rd_ptr_q   <= rd_ptr_q + PtrW'(pop);
            overflow_q <= overflow_d;
            status_q   <= status_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q[AddrW-1:0]] <= pb.out_port;
    end

    assign tx        = tx_q;
    assign pb.status = status_q;
endmodule

// File: tb/tb_cipher_uart_tx.sv
// Directed bench for cipher_uart_tx (default 8N1 build): vector table plus hand-written sequences.
module tb_cipher_uart_tx;
    logic clk = 1'b0;
    logic reset;
    logic tx, busy, tx2, busy2;
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cipher_uart_tx_if pb ();
    cipher_uart_tx_if pb2 ();

    cipher_uart_tx #(
        .CLKS_PER_BIT(4), .FIFO_DEPTH(8), .DATA_PORT(8'h20), .STATUS_PORT(8'h21)
    ) dut (
        .clk(clk), .reset(reset), .pb(pb), .tx(tx), .busy(busy)
    );

    // Shared data/status port so a push and a status read can land on the same edge.
    cipher_uart_tx #(
        .CLKS_PER_BIT(2), .FIFO_DEPTH(2), .DATA_PORT(8'h30), .STATUS_PORT(8'h30)
    ) dut2 (
        .clk(clk), .reset(reset), .pb(pb2), .tx(tx2), .busy(busy2)
    );

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] port;
        logic [7:0] data;
        logic       exp_tx;
        logic       exp_busy;
        logic [7:0] exp_status;
    } vec_t;

    vec_t vecs[64];
    int   nv;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [7:0] port,
                         input logic [7:0] data);
        pb.write_strobe = wr;
        pb.read_strobe  = rd;
        pb.port_id      = port;
        pb.out_port     = data;
    endtask

    task automatic drive2(input logic wr, input logic rd, input logic [7:0] data);
        pb2.write_strobe = wr;
        pb2.read_strobe  = rd;
        pb2.port_id      = 8'h30;
        pb2.out_port     = data;
    endtask

    // Receives one frame; sampling is cycle-exact at the middle of each 4-clock bit.
    task automatic rx_byte(output logic [7:0] b, output int s, output bit ok);
        int guard = 0;
        ok = 1'b1;
        b  = 8'h00;
        s  = 0;
        do begin
            @(posedge clk); #1;
            guard++;
        end while (tx === 1'b1 && guard < 300);
        if (tx !== 1'b0) begin
            ok = 1'b0;
            n_vec++;
            n_bad++;
            $display("FAIL rx_start: tx=%b, no start bit within 300 cycles", tx);
            return;
        end
        s = cyc;
        repeat (6) @(posedge clk);
        #1 b[0] = tx;
        for (int i = 1; i < 8; i++) begin
            repeat (4) @(posedge clk);
            #1 b[i] = tx;
        end
        repeat (4) @(posedge clk);
        #1 check8("rx_stop", {7'b0, tx}, 8'h01);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [9:0]  frame_a5;
        logic [7:0]  rb;
        int          s_now, s_prev, low_cnt;
        bit          ok;

        drive(1'b0, 1'b0, 8'h00, 8'h00);
        drive2(1'b0, 1'b0, 8'h00);
        reset = 1'b1;
        #12;
        check8("reset.tx", {7'b0, tx}, 8'h01);
        check8("reset.busy", {7'b0, busy}, 8'h00);
        check8("reset.status", pb.status, 8'h01);
        @(negedge clk) reset = 1'b0;

        // ---- overflow set-wins on the shared-port instance ----
        for (int i = 0; i < 5; i++) begin
            @(negedge clk) drive2(1'b1, (i == 4), 8'(i));
        end
        @(negedge clk) drive2(1'b0, 1'b1, 8'h00);
        @(posedge clk); #1 check8("ovf_set_wins", pb2.status, 8'h0E);
        @(negedge clk) drive2(1'b0, 1'b0, 8'h00);
        @(posedge clk); #1 check8("ovf_cleared2", pb2.status, 8'h06);

        // ---- vector table: 8'hA5 frame, then ignored ports ----
        frame_a5 = {1'b1, 8'hA5, 1'b0};   // stop, data, start (bit0 first on the line)
        for (int k = 0; k <= 42; k++) begin
            vecs[k].wr         = (k == 0);
            vecs[k].rd         = 1'b0;
            vecs[k].port       = (k == 0) ? 8'h20 : 8'h00;
            vecs[k].data       = (k == 0) ? 8'hA5 : 8'h00;
            vecs[k].exp_tx     = (k < 2 || k >= 42) ? 1'b1 : frame_a5[(k - 2) / 4];
            vecs[k].exp_busy   = (k <= 40);
            vecs[k].exp_status = (k == 0) ? 8'h01 : (k == 1) ? 8'h00 :
                                 (k <= 41) ? 8'h05 : 8'h01;
        end
        vecs[43] = '{1'b1, 1'b0, 8'h22, 8'h5A, 1'b1, 1'b0, 8'h01};
        vecs[44] = '{1'b0, 1'b1, 8'h20, 8'h00, 1'b1, 1'b0, 8'h01};
        vecs[45] = '{1'b1, 1'b0, 8'h21, 8'h77, 1'b1, 1'b0, 8'h01};
        vecs[46] = '{1'b0, 1'b1, 8'h22, 8'h00, 1'b1, 1'b0, 8'h01};
        vecs[47] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h01};
        nv = 48;

        for (int i = 0; i < nv; i++) begin
            @(negedge clk) drive(vecs[i].wr, vecs[i].rd, vecs[i].port, vecs[i].data);
            @(posedge clk); #1;
            check8($sformatf("vec%0d.tx", i), {7'b0, tx}, {7'b0, vecs[i].exp_tx});
            check8($sformatf("vec%0d.busy", i), {7'b0, busy}, {7'b0, vecs[i].exp_busy});
            check8($sformatf("vec%0d.status", i), pb.status, vecs[i].exp_status);
        end
        @(negedge clk) drive(1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) @(posedge clk);

        // ---- 9-byte burst, 10th write overflows, then status-read clear ----
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    @(negedge clk) drive(1'b1, 1'b0, 8'h20, 8'(i));
                end
                @(negedge clk) drive(1'b1, 1'b0, 8'h20, 8'h09);
                @(posedge clk); #1 check8("burst_full", pb.status, 8'h06);
                @(negedge clk) drive(1'b0, 1'b1, 8'h21, 8'h00);
                @(posedge clk); #1 check8("ovf_set", pb.status, 8'h0E);
                @(negedge clk) drive(1'b0, 1'b0, 8'h00, 8'h00);
                @(posedge clk); #1 check8("ovf_clear", pb.status, 8'h06);
            end
            begin
                s_prev = 0;
                for (int f = 0; f < 9; f++) begin
                    rx_byte(rb, s_now, ok);
                    if (ok) begin
                        check8($sformatf("burst_byte%0d", f), rb, 8'(f));
                        if (f > 0) check8($sformatf("spacing%0d", f), 8'(s_now - s_prev), 8'd41);
                        s_prev = s_now;
                    end
                end
            end
        join
        low_cnt = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (tx !== 1'b1) low_cnt++;
        end
        check8("no_extra_frame", 8'(low_cnt), 8'd0);
        check8("burst_idle.busy", {7'b0, busy}, 8'h00);
        check8("burst_idle.status", pb.status, 8'h01);

        // ---- reset during DATA bit 3 of 8'h3C with two bytes queued ----
        @(negedge clk) drive(1'b1, 1'b0, 8'h20, 8'h3C);
        @(negedge clk) drive(1'b1, 1'b0, 8'h20, 8'h11);
        @(negedge clk) drive(1'b1, 1'b0, 8'h20, 8'h22);
        @(negedge clk) drive(1'b0, 1'b0, 8'h00, 8'h00);
        repeat (16) @(posedge clk);
        #1;
        check8("pre_reset.busy", {7'b0, busy}, 8'h01);
        check8("pre_reset.tx_bit3", {7'b0, tx}, 8'h01);
        #2 reset = 1'b1;
        #1;
        check8("mid_reset.tx", {7'b0, tx}, 8'h01);
        check8("mid_reset.busy", {7'b0, busy}, 8'h00);
        check8("mid_reset.status", pb.status, 8'h01);
        @(negedge clk) reset = 1'b0;
        low_cnt = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (tx !== 1'b1) low_cnt++;
        end
        check8("post_reset.no_frame", 8'(low_cnt), 8'd0);
        check8("post_reset.status", pb.status, 8'h01);
        check8("post_reset.busy", {7'b0, busy}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
